// File: rtl/par2ser_pkg.sv
// Shared constants and helpers for the parallel-to-serial FIFO serialiser.
package par2ser_pkg;

    localparam logic [31:0] IDLE_DEFAULT = 32'hBC;
    localparam int unsigned STATS_W = 16;

    // Saturating increment for the optional slot statistics counters.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/p2s_fifo_buf.sv
// Synchronous FIFO buffering parallel words ahead of the serialiser.
module p2s_fifo_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_8f,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk_8f) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/par2ser_fifo.sv
// Buffered parallel-to-serial converter sending IDLE words when the buffer is empty.
// Optional slot statistics outputs are enabled with macro P2S_STATS_EN.
module par2ser_fifo
    import par2ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] IDLE      = IDLE_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk_8f,
    input  logic                     reset_L,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic                     data_out_P2S,
    output logic                     frame_start,
    output logic                     sending_data,
`ifdef P2S_STATS_EN
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [STATS_W-1:0]       data_words,
    output logic [STATS_W-1:0]       idle_words
`else
    output logic [$clog2(DEPTH):0]   fifo_level
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IDLE_W  = IDLE[WIDTH-1:0];

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] word_q;
    logic             word_data_q;
    logic [CW-1:0]    bit_idx;
    logic             slot_end;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;

    assign ready_out = !full;
    assign push      = valid_in && ready_out;
    assign slot_end  = (cnt_q == CNT_MAX);
    // Pop only at a slot boundary; a word pushed on that same edge waits a slot.
    assign pop       = slot_end && !empty;
    assign bit_idx   = MSB_FIRST ? (CNT_MAX - cnt_q) : cnt_q;

    p2s_fifo_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_8f  (clk_8f),
        .reset_L (reset_L),
        .push    (push),
        .pop     (pop),
        .din     (data_in),
        .head    (head),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q        <= '0;
            word_q       <= IDLE_W;
            word_data_q  <= 1'b0;
            data_out_P2S <= 1'b0;
            frame_start  <= 1'b0;
            sending_data <= 1'b0;
        end else begin
            data_out_P2S <= word_q[bit_idx];
            frame_start  <= (cnt_q == '0);
            sending_data <= word_data_q;
            if (slot_end) begin
                cnt_q       <= '0;
                word_q      <= empty ? IDLE_W : head;
                word_data_q <= !empty;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef P2S_STATS_EN
    logic [STATS_W-1:0] data_words_q;
    logic [STATS_W-1:0] idle_words_q;

    assign data_words = data_words_q;
    assign idle_words = idle_words_q;

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            data_words_q <= '0;
            idle_words_q <= '0;
        end else if (slot_end) begin
            if (empty) idle_words_q <= sat_inc(idle_words_q);
            else       data_words_q <= sat_inc(data_words_q);
        end
    end
`endif

endmodule

// File: tb/tb_par2ser_fifo.sv
// Randomised and directed bench for par2ser_fifo against a slot-level stream model.
module tb_par2ser_fifo;
    import par2ser_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
    localparam logic [W-1:0] IDLE_WORD = 8'hBC;

    logic                 clk_8f   = 1'b0;
    logic                 reset_L  = 1'b0;
    logic                 valid_in = 1'b0;
    logic [W-1:0]         data_in  = '0;
    logic                 ready_out, ser_msb, frame_start, sending_data;
    logic [$clog2(D):0]   fifo_level;
    logic                 ready_lsb, ser_lsb, frame_lsb, send_lsb;
    logic [$clog2(D):0]   level_lsb;
`ifdef P2S_STATS_EN
    logic [STATS_W-1:0]   data_words, idle_words, data_words_lsb, idle_words_lsb;
`endif

    always #5 clk_8f = ~clk_8f;

    par2ser_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut (
        .clk_8f       (clk_8f),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_out_P2S (ser_msb),
        .frame_start  (frame_start),
        .sending_data (sending_data),
`ifdef P2S_STATS_EN
        .fifo_level   (fifo_level),
        .data_words   (data_words),
        .idle_words   (idle_words)
`else
        .fifo_level   (fifo_level)
`endif
    );

    par2ser_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_8f       (clk_8f),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_lsb),
        .data_out_P2S (ser_lsb),
        .frame_start  (frame_lsb),
        .sending_data (send_lsb),
`ifdef P2S_STATS_EN
        .fifo_level   (level_lsb),
        .data_words   (data_words_lsb),
        .idle_words   (idle_words_lsb)
`else
        .fifo_level   (level_lsb)
`endif
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: queue of accepted words plus the word occupying the current slot.
    logic [W-1:0] q[$];
    logic [W-1:0] cur_word;
    logic         cur_data;
    int           n;
    int           last_p;
    bit           accepted;
    logic         exp_msb, exp_lsb, exp_frame, exp_send;
    logic [15:0]  stat_data, stat_idle;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur_word  = IDLE_WORD;
        cur_data  = 1'b0;
        n         = 0;
        last_p    = 0;
        stat_data = '0;
        stat_idle = '0;
    endtask

    task automatic model_edge();
        int p;
        bit push_ok;
        p        = n % W;
        push_ok  = valid_in && (q.size() < D);
        accepted = push_ok;
        exp_msb   = cur_word[W-1-p];
        exp_lsb   = cur_word[p];
        exp_frame = (p == 0);
        exp_send  = cur_data;
        last_p    = p;
        if (p == W-1) begin
            if (q.size() > 0) begin
                cur_word  = q.pop_front();
                cur_data  = 1'b1;
                stat_data = (stat_data == 16'hFFFF) ? stat_data : stat_data + 16'd1;
            end else begin
                cur_word  = IDLE_WORD;
                cur_data  = 1'b0;
                stat_idle = (stat_idle == 16'hFFFF) ? stat_idle : stat_idle + 16'd1;
            end
        end
        if (push_ok) q.push_back(data_in);
        n++;
    endtask

    task automatic compare_all();
        check_eq("ser_msb", 32'(ser_msb), 32'(exp_msb));
        check_eq("ser_lsb", 32'(ser_lsb), 32'(exp_lsb));
        check_eq("frame_start", 32'(frame_start), 32'(exp_frame));
        check_eq("sending_data", 32'(sending_data), 32'(exp_send));
        check_eq("fifo_level", 32'(fifo_level), 32'(q.size()));
        check_eq("ready_out", 32'(ready_out), 32'(q.size() < D));
`ifdef P2S_STATS_EN
        check_eq("data_words", 32'(data_words), 32'(stat_data));
        check_eq("idle_words", 32'(idle_words), 32'(stat_idle));
`endif
    endtask

    task automatic cycle();
        @(posedge clk_8f);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int k);
        valid_in = 1'b0;
        repeat (k) cycle();
    endtask

    task automatic push_word(input logic [W-1:0] d);
        valid_in = 1'b1;
        data_in  = d;
        accepted = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (accepted) break;
        end
        check_eq("push_accept", 32'(accepted), 32'd1);
        valid_in = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ser"}, 32'(ser_msb), 32'd0);
        check_eq({tag, "_ser_lsb"}, 32'(ser_lsb), 32'd0);
        check_eq({tag, "_frame"}, 32'(frame_start), 32'd0);
        check_eq({tag, "_send"}, 32'(sending_data), 32'd0);
        check_eq({tag, "_level"}, 32'(fifo_level), 32'd0);
        check_eq({tag, "_ready"}, 32'(ready_out), 32'd1);
`ifdef P2S_STATS_EN
        check_eq({tag, "_data_words"}, 32'(data_words), 32'd0);
        check_eq({tag, "_idle_words"}, 32'(idle_words), 32'd0);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        #2 reset_L = 1'b0;
        #1 check_reset_state(tag);
        valid_in = 1'b0;
        repeat (2) @(negedge clk_8f);
        model_reset();
        reset_L = 1'b1;
    endtask

    initial begin
        bit found;
        int rate;
        model_reset();
        #12 check_reset_state("por");
        @(negedge clk_8f);
        reset_L = 1'b1;

        idle(16);                       // pure IDLE stream
        push_word(8'hA5);
        idle(24);
        push_word(8'h01);               // LSB-first instance sends 1,0,0,0,0,0,0,0
        idle(24);

        pulse_reset("rst_fill");
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        check_eq("full_level", 32'(fifo_level), 32'd4);
        check_eq("full_ready", 32'(ready_out), 32'd0);
        push_word(8'h55);
        idle(56);

        // Reset while the 4th bit of a data word is on the line, 2 words still buffered.
        push_word(8'h66);
        push_word(8'h77);
        push_word(8'h88);
        found = 1'b0;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (exp_send && last_p == 3) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("mid_word_found", 32'(found), 32'd1);
        check_eq("mid_word_buffered", 32'(fifo_level), 32'd2);
        pulse_reset("rst_mid");
        idle(16);

`ifdef P2S_STATS_EN
        pulse_reset("rst_stats");
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        idle(64 - n);
        check_eq("stats_data3", 32'(data_words), 32'd3);
        check_eq("stats_idle5", 32'(idle_words), 32'd5);
        force dut.data_words_q = 16'hFFFF;
        #1 release dut.data_words_q;
        stat_data = 16'hFFFF;
        valid_in = 1'b1;
        repeat (24) begin
            data_in = W'($urandom);
            cycle();
        end
        idle(16);
        check_eq("stats_saturate", 32'(data_words), 32'hFFFF);
`endif

        for (int seg = 0; seg < 4; seg++) begin
            rate = (seg == 0) ? 15 : (seg == 1) ? 50 : (seg == 2) ? 95 : 30;
            if (seg == 3) pulse_reset("rst_rand");
            repeat (150) begin
                valid_in = ($urandom_range(0, 99) < rate);
                data_in  = W'($urandom);
                cycle();
            end
        end
        idle(48);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par2ser_fifo.md
PAR2SER_FIFO -- requirements
Module: par2ser_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (2..32).
REQ-002 SHALL have parameter DEPTH, default 4, input buffer depth in words (power of 2, >=2).
REQ-003 SHALL have parameter IDLE, default 'hBC, idle word sent when the buffer is empty; zero-extended or truncated to WIDTH.
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-005 SHALL have port clk_8f, input, 1, bit-rate clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset_L, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data_in, input, WIDTH, parallel word.
REQ-008 SHALL have port valid_in, input, 1, data_in valid.
REQ-009 SHALL have port ready_out, output, 1, buffer can accept a word.
REQ-010 SHALL have port data_out_P2S, output, 1, serial bit, registered.
REQ-011 SHALL have port frame_start, output, 1, high while data_out_P2S carries the first bit of a word.
REQ-012 SHALL have port sending_data, output, 1, high while the word on data_out_P2S came from the buffer (low for IDLE).
REQ-013 SHALL have port fifo_level, output, $clog2(DEPTH)+1, words held in the buffer.

Function
REQ-014 SHALL accept a word on any edge where valid_in && ready_out; ready_out = (fifo_level < DEPTH), derived from registered state only.
REQ-015 SHALL keep ready_out low when full; a pop on the same edge does not admit a push (no full-bypass).
REQ-016 SHALL serialise a word slot over WIDTH cycles using bit counter cnt, 0..WIDTH-1, wrapping to 0.
REQ-017 SHALL, on each edge, register data_out_P2S <= word_reg[MSB_FIRST ? WIDTH-1-cnt : cnt], and register frame_start and sending_data for the same bit.
REQ-018 SHALL, on the edge where cnt == WIDTH-1, load word_reg with the buffer head and pop it if non-empty, otherwise load IDLE; the data flag follows.
REQ-019 SHALL not bypass an empty buffer: a push and a slot boundary on the same edge load IDLE, and the pushed word waits one slot.
REQ-020 SHALL give latency: a word pushed into an empty buffer at edge k appears as its first bit on data_out_P2S one edge after the next slot boundary.
REQ-021 SHALL update fifo_level by +1 for a push only, -1 for a pop only, and 0 for both or neither.
REQ-022 SHALL transmit the words in push order, with no duplication or loss.

Reset
REQ-023 SHALL, while reset_L = 0, immediately force data_out_P2S=0, frame_start=0, sending_data=0, cnt=0, word_reg=IDLE, buffer empty, fifo_level=0, ready_out=1.
REQ-024 SHALL discard buffered and in-flight words on a reset asserted mid-word; the first slot after release is IDLE.

Configuration
REQ-025 SHALL, with macro P2S_STATS_EN defined, add 16-bit outputs data_words and idle_words counting slot boundaries that load buffer words or IDLE respectively, saturating at 'hFFFF and cleared by reset.
REQ-026 SHALL, with P2S_STATS_EN undefined, omit those ports and their logic entirely.

Structure
REQ-027 SHALL define the default IDLE constant ('hBC) and the stats counter width (16) in shared package par2ser_pkg.
REQ-028 SHALL place the buffer in sub-module p2s_fifo_buf (sync FIFO with push, pop, head, level, full, empty, async reset_L); the serialiser stays in par2ser_fifo.

Verification
REQ-029 SHALL cover: reset release, no valid_in, WIDTH=8 -> data_out_P2S repeats 1,0,1,1,1,1,0,0; frame_start every 8th cycle; sending_data=0.
REQ-030 SHALL cover: one push of 'hA5 -> next slot serialises 1,0,1,0,0,1,0,1 with sending_data=1, then IDLE resumes.
REQ-031 SHALL cover: MSB_FIRST=0 with a push of 'h01 -> serial 1,0,0,0,0,0,0,0.
REQ-032 SHALL cover: pushes 'h11, 'h22, 'h33, 'h44, 'h55 back-to-back, DEPTH=4 -> ready_out low after the 4th push, fifo_level=4, the 5th word held until a pop, and the output order 11,22,33,44,55.
REQ-033 SHALL cover: reset_L pulsed low at cnt=3 of a data word with 2 words buffered -> data_out_P2S=0 at once, fifo_level=0, and the next slot is IDLE.
REQ-034 SHALL cover: with P2S_STATS_EN, 3 data slots and 5 idle slots -> data_words=3, idle_words=5; a forced count of 'hFFFF holds.
